// File: rtl/moddiv_pkg.sv
// Shared state encoding and default sizing for the modular-division issuer.
package moddiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RECOVER,
    DONE
  } state_t;

  localparam int MODDIV_DATA_LEN   = 256;
  localparam int MODDIV_CNT_W      = 11;
  localparam int MODDIV_TIMEOUT    = 1040;
  localparam int MODDIV_RST_CYCLES = 2;

endpackage

// File: rtl/moddiv_issuer_if.sv
// Request, engine and completion signals of the division issuer; master is the issuer side.
interface moddiv_issuer_if
  import moddiv_pkg::*;
#(
  parameter int DATA_LEN = MODDIV_DATA_LEN,
  parameter int CNT_W    = MODDIV_CNT_W
);

  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_x;
  logic [DATA_LEN-1:0] in_y;
  logic [DATA_LEN-1:0] in_p;

  logic                eng_start;
  logic                eng_finish;
  logic [DATA_LEN-1:0] eng_result;
  logic [DATA_LEN-1:0] eng_x;
  logic [DATA_LEN-1:0] eng_y;
  logic [DATA_LEN-1:0] eng_p;
  logic                eng_rst;

  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_result;
  logic                out_err;
  logic [CNT_W-1:0]    out_cycles;

  modport master (
    input  in_valid, in_x, in_y, in_p, eng_finish, eng_result, out_ready,
    output in_ready, eng_start, eng_x, eng_y, eng_p, eng_rst,
    output out_valid, out_result, out_err, out_cycles
  );

  modport slave (
    output in_valid, in_x, in_y, in_p, eng_finish, eng_result, out_ready,
    input  in_ready, eng_start, eng_x, eng_y, eng_p, eng_rst,
    input  out_valid, out_result, out_err, out_cycles
  );

endinterface

// File: rtl/moddiv_watchdog.sv
// Engine-cycle counter shared by WAIT (timeout) and RECOVER (reset hold); 1-cycle update.
module moddiv_watchdog #(
  parameter int CNT_W      = 11,
  parameter int TIMEOUT    = 1040,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             timeout_o,
  output logic             rst_done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign timeout_o  = (cnt_q == CNT_W'(TIMEOUT));
  assign rst_done_o = (cnt_q == CNT_W'(RST_CYCLES));

endmodule

// File: rtl/moddiv_issuer.sv
// Issues one modular division per request: latch operands, pulse start, await finish or time out.
// Accept-to-completion >= 3 cycles; one request in flight, completion held until out_ready.
module moddiv_issuer
  import moddiv_pkg::*;
#(
  parameter int DATA_LEN   = MODDIV_DATA_LEN,
  parameter int TIMEOUT    = MODDIV_TIMEOUT,
  parameter int RST_CYCLES = MODDIV_RST_CYCLES,
  parameter int CNT_W      = MODDIV_CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  moddiv_issuer_if.master bus
);

  state_t              state_q;
  logic                in_ready_q;
  logic                eng_start_q;
  logic                eng_rst_q;
  logic                out_valid_q;
  logic                out_err_q;
  logic [DATA_LEN-1:0] out_result_q;
  logic [CNT_W-1:0]    out_cycles_q;
  logic [DATA_LEN-1:0] eng_x_q;
  logic [DATA_LEN-1:0] eng_y_q;
  logic [DATA_LEN-1:0] eng_p_q;

  logic             wd_load;
  logic             wd_inc;
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_timeout;
  logic             wd_rst_done;

  // Reload to 1 both on entering WAIT and on entering RECOVER; finish beats timeout.
  assign wd_load = (state_q == START) ||
                   ((state_q == WAIT) && !bus.eng_finish && wd_timeout);
  assign wd_inc  = ((state_q == WAIT) && !bus.eng_finish && !wd_timeout) ||
                   ((state_q == RECOVER) && !wd_rst_done);

  moddiv_watchdog #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .RST_CYCLES (RST_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (wd_load),
    .inc_i      (wd_inc),
    .cnt_o      (wd_cnt),
    .timeout_o  (wd_timeout),
    .rst_done_o (wd_rst_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_rst_q    <= 1'b1;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_result_q <= '0;
      out_cycles_q <= '0;
      eng_x_q      <= '0;
      eng_y_q      <= '0;
      eng_p_q      <= '0;
    end else begin
      eng_start_q <= 1'b0;
      eng_rst_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            eng_x_q     <= bus.in_x;
            eng_y_q     <= bus.in_y;
            eng_p_q     <= bus.in_p;
            in_ready_q  <= 1'b0;
            eng_start_q <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.eng_finish) begin
            out_result_q <= bus.eng_result;
            out_err_q    <= 1'b0;
            out_cycles_q <= wd_cnt;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else if (wd_timeout) begin
            out_result_q <= '0;
            out_err_q    <= 1'b1;
            out_cycles_q <= CNT_W'(TIMEOUT);
            eng_rst_q    <= 1'b1;
            state_q      <= RECOVER;
          end
        end
        RECOVER: begin
          if (wd_rst_done) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            eng_rst_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.eng_start  = eng_start_q;
  assign bus.eng_rst    = eng_rst_q;
  assign bus.eng_x      = eng_x_q;
  assign bus.eng_y      = eng_y_q;
  assign bus.eng_p      = eng_p_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_err    = out_err_q;
  assign bus.out_cycles = out_cycles_q;

endmodule

// File: tb/tb_moddiv_issuer.sv
// Directed and randomized requests against a request-level model of the division issuer.
module tb_moddiv_issuer;

  localparam int DL      = 256;
  localparam int CW      = 11;
  localparam int TIMEOUT = 1040;
  localparam int RSTC    = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  moddiv_issuer_if #(.DATA_LEN(DL), .CNT_W(CW)) bus ();

  moddiv_issuer #(
    .DATA_LEN   (DL),
    .TIMEOUT    (TIMEOUT),
    .RST_CYCLES (RSTC),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // x / y mod p by brute-force inverse, p prime.
  function automatic int moddiv(input int x, input int y, input int p);
    int inv;
    inv = 0;
    for (int i = 1; i < p; i++) begin
      if (((y * i) % p) == 1) inv = i;
    end
    return (x * inv) % p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fin_at = WAIT cycle of eng_finish (0 = never); abort_at > 0 drops rst_n in that WAIT cycle.
  task automatic run_req(input string tag, input logic [DL-1:0] x, input logic [DL-1:0] y,
                         input logic [DL-1:0] p, input int fin_at, input logic [DL-1:0] res,
                         input int bp, input int abort_at);
    int c, starts, rsts, exp_lat, exp_rsts, exp_cyc;
    logic [DL-1:0] exp_res;
    logic exp_err;
    bit ok;
    bit finishes;
    finishes = (fin_at >= 1) && (fin_at <= TIMEOUT);
    exp_res  = finishes ? res : '0;
    exp_err  = !finishes;
    exp_cyc  = finishes ? fin_at : TIMEOUT;
    exp_rsts = finishes ? 0 : RSTC;
    exp_lat  = finishes ? fin_at + 1 : TIMEOUT + 1 + RSTC;

    c = 0;
    while (bus.in_ready !== 1'b1 && c < 10) begin
      tick();
      c++;
    end
    check({tag, ".in_ready"}, DL'(bus.in_ready), DL'(1));
    bus.in_valid = 1'b1;
    bus.in_x = x;
    bus.in_y = y;
    bus.in_p = p;
    tick();
    bus.in_valid = 1'b0;
    bus.in_x = ~x;
    bus.in_y = ~y;
    bus.in_p = ~p;
    check({tag, ".start"}, DL'(bus.eng_start), DL'(1));
    check({tag, ".ops"}, (bus.eng_x ^ x) | (bus.eng_y ^ y) | (bus.eng_p ^ p), '0);

    starts = 1;
    rsts = 0;
    c = 0;
    while (bus.out_valid !== 1'b1 && c < TIMEOUT + 20) begin
      if (abort_at > 0 && c == abort_at) begin
        rst_n = 1'b0;
        #1;
        return;
      end
      bus.eng_finish = (fin_at > 0) && (c == fin_at);
      bus.eng_result = bus.eng_finish ? res : {8{$urandom}};
      tick();
      c++;
      starts += int'(bus.eng_start);
      rsts   += int'(bus.eng_rst);
    end
    bus.eng_finish = 1'b0;
    check({tag, ".latency"}, DL'(c), DL'(exp_lat));
    check({tag, ".out_valid"}, DL'(bus.out_valid), DL'(1));
    check({tag, ".result"}, bus.out_result, exp_res);
    check({tag, ".err"}, DL'(bus.out_err), DL'(exp_err));
    check({tag, ".cycles"}, DL'(bus.out_cycles), DL'(exp_cyc));
    check({tag, ".starts"}, DL'(starts), DL'(1));
    check({tag, ".eng_rst"}, DL'(rsts), DL'(exp_rsts));

    bus.out_ready = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < bp; i++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_result !== exp_res || bus.in_ready !== 1'b0 ||
          bus.out_cycles !== CW'(exp_cyc) || bus.out_err !== exp_err) ok = 1'b0;
    end
    if (bp > 0) check({tag, ".hold"}, DL'(ok), DL'(1));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".released"}, DL'({bus.out_valid, bus.in_ready}), DL'(2'b01));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".in_ready"}, DL'(bus.in_ready), '0);
    check({tag, ".eng_start"}, DL'(bus.eng_start), '0);
    check({tag, ".out_valid"}, DL'(bus.out_valid), '0);
    check({tag, ".out_err"}, DL'(bus.out_err), '0);
    check({tag, ".out_result"}, bus.out_result, '0);
    check({tag, ".out_cycles"}, DL'(bus.out_cycles), '0);
    check({tag, ".eng_ops"}, bus.eng_x | bus.eng_y | bus.eng_p, '0);
    check({tag, ".eng_rst"}, DL'(bus.eng_rst), DL'(1));
  endtask

  initial begin
    logic [DL-1:0] ax, ay, ap, bx, by, bp_, r1, r2;
    int primes[8] = '{19, 23, 29, 31, 37, 41, 43, 47};
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_y = '0;
    bus.in_p = '0;
    bus.eng_finish = 1'b0;
    bus.eng_result = '0;
    bus.out_ready = 1'b0;

    #2 rst_n = 1'b0;
    #1 check_reset_vals("por");
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("por.eng_rst_clear", DL'(bus.eng_rst), '0);
    check("por.in_ready", DL'(bus.in_ready), DL'(1));

    // normal, backpressure, coincident finish/timeout, pure timeout
    run_req("t1", 6, 3, 'h13, 10, DL'(moddiv(6, 3, 19)), 0, 0);
    run_req("t2", 6, 3, 'h13, 10, DL'(moddiv(6, 3, 19)), 5, 0);
    run_req("t4", 5, 7, 'h1d, TIMEOUT, 'hAB, 0, 0);
    run_req("t3", 9, 4, 'h17, 0, '0, 2, 0);

    // reset while waiting, then recover
    run_req("t5", 11, 2, 'h1f, 0, '0, 0, 50);
    check_reset_vals("t5.async");
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("t5.eng_rst_clear", DL'(bus.eng_rst), '0);
    check("t5.in_ready", DL'(bus.in_ready), DL'(1));
    run_req("t5b", 8, 5, 'h25, 3, DL'(moddiv(8, 5, 37)), 0, 0);

    // spurious finish while idle
    bus.eng_finish = 1'b1;
    bus.eng_result = 'h55;
    tick();
    bus.eng_finish = 1'b0;
    tick();
    check("t6.spur", DL'({bus.out_valid, bus.in_ready, bus.eng_start}), DL'(3'b010));

    // back-to-back with in_valid held
    ax = 12; ay = 7; ap = 41; bx = 20; by = 9; bp_ = 43;
    r1 = DL'(moddiv(12, 7, 41));
    r2 = DL'(moddiv(20, 9, 43));
    bus.in_valid = 1'b1;
    bus.in_x = ax; bus.in_y = ay; bus.in_p = ap;
    bus.out_ready = 1'b1;
    tick();
    check("t6.start1", DL'(bus.eng_start), DL'(1));
    bus.in_x = bx; bus.in_y = by; bus.in_p = bp_;
    tick();
    bus.eng_finish = 1'b1;
    bus.eng_result = r1;
    tick();
    bus.eng_finish = 1'b0;
    check("t6.res1", bus.out_result, r1);
    check("t6.ops_held", (bus.eng_x ^ ax) | (bus.eng_y ^ ay) | (bus.eng_p ^ ap), '0);
    tick();
    check("t6.idle", DL'({bus.out_valid, bus.in_ready, bus.eng_start}), DL'(3'b010));
    check("t6.ops_idle", (bus.eng_x ^ ax) | (bus.eng_y ^ ay) | (bus.eng_p ^ ap), '0);
    tick();
    bus.in_valid = 1'b0;
    check("t6.start2", DL'(bus.eng_start), DL'(1));
    check("t6.ops2", (bus.eng_x ^ bx) | (bus.eng_y ^ by) | (bus.eng_p ^ bp_), '0);
    tick();
    bus.eng_finish = 1'b1;
    bus.eng_result = r2;
    tick();
    bus.eng_finish = 1'b0;
    check("t6.res2", bus.out_result, r2);
    check("t6.cyc2", DL'(bus.out_cycles), DL'(1));
    tick();
    bus.out_ready = 1'b0;
    check("t6.done2", DL'({bus.out_valid, bus.in_ready}), DL'(2'b01));

    // randomized requests
    for (int n = 0; n < 8; n++) begin
      int p, x, y;
      p = primes[$urandom_range(0, 7)];
      x = $urandom_range(1, p - 1);
      y = $urandom_range(1, p - 1);
      run_req($sformatf("rnd%0d", n), DL'(x), DL'(y), DL'(p), $urandom_range(1, 40),
              DL'(moddiv(x, y, p)), $urandom_range(0, 3), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
